mm_seq_ctrl: RTL and testbench

- Sequencer for one systolic matrix-multiply array run.
- On a start pulse it:
  - clears the array with its synchronous active-high reset;
  - waits for the array's finished flag;
  - drains all ROWS_OUT*COLS_OUT sums through the array's registered result read port into a destination RAM write port, with backpressure.
- Sits between the top-level layer scheduler (start/done) and one multiply array instance plus its result RAM.

---
 rtl/mm_seq_ctrl_if.sv | 30 +++
 rtl/mm_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mm_seq_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mm_seq_ctrl_if.sv
// Signal bundle between the matmul sequencer, its layer scheduler, the
// multiply array result port and the destination RAM write port.
interface mm_seq_ctrl_if #(
   parameter int INDEX_BITS = 16,
   parameter int BIT_RES    = 32
);
   logic                  start;
   logic [INDEX_BITS-1:0] base_addr;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic                  mm_reset;
   logic                  mm_finished;
   logic [INDEX_BITS-1:0] mm_res_addr;
   logic [BIT_RES-1:0]    mm_res_out;
   logic                  wr_en;
   logic [INDEX_BITS-1:0] wr_addr;
   logic [BIT_RES-1:0]    wr_data;
   logic                  wr_ready;

   modport master (
      input  start, base_addr, mm_finished, mm_res_out, wr_ready,
      output busy, done, error, mm_reset, mm_res_addr, wr_en, wr_addr, wr_data
   );

   modport slave (
      output start, base_addr, mm_finished, mm_res_out, wr_ready,
      input  busy, done, error, mm_reset, mm_res_addr, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/mm_seq_ctrl.sv
// Sequencer for one systolic matmul run: clear the array, wait for its
// finished flag, then drain every sum into the destination RAM.
module mm_seq_ctrl #(
   parameter int ROWS_OUT     = 3,
   parameter int COLS_OUT     = 3,
   parameter int INDEX_BITS   = 16,
   parameter int BIT_RES      = 32,
   parameter int CLEAR_CYCLES = 2,
   parameter int TIMEOUT      = 1024
) (
   input  logic           clk,
   input  logic           reset,
   mm_seq_ctrl_if.master  bus
);
   localparam int N     = ROWS_OUT * COLS_OUT;
   localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit TMO_EN = (TIMEOUT != 32'sd0);
   localparam logic [CLR_W-1:0]      CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
   localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [INDEX_BITS-1:0] IDX_LAST = INDEX_BITS'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_RUN    = 3'd2,
      S_DADDR  = 3'd3,
      S_DWRITE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t                state_r, state_s;
   logic [1:0]            rst_sync_r;
   logic                  srst_s;
   logic [INDEX_BITS-1:0] base_r, base_s;
   logic [INDEX_BITS-1:0] idx_r, idx_s;
   logic [CLR_W-1:0]      clr_r, clr_s;
   logic [TMO_W-1:0]      tmo_r, tmo_s;
   logic                  error_r, error_s;
   logic                  busy_r, done_r, mm_reset_r, wr_en_r;
   logic [INDEX_BITS-1:0] wr_addr_r, res_addr_r;
   logic [BIT_RES-1:0]    res_s;

   // Two-flop release of the asynchronous reset; the FSM stays cleared until it completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   assign srst_s = ~rst_sync_r[1];

   // Next-state and next-datapath decode.
   always_comb begin
      state_s = state_r;
      base_s  = base_r;
      idx_s   = idx_r;
      clr_s   = clr_r;
      tmo_s   = tmo_r;
      error_s = error_r;
      case (state_r)
         S_IDLE: begin
            if (bus.start) begin
               base_s  = bus.base_addr;
               error_s = 1'b0;
               clr_s   = {CLR_W{1'b0}};
               state_s = S_CLEAR;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_CLEAR: begin
            clr_s = clr_r + CLR_W'(1);
            if (clr_r == CLR_LAST) begin
               tmo_s   = {TMO_W{1'b0}};
               state_s = S_RUN;
            end else begin
               state_s = S_CLEAR;
            end
         end
         S_RUN: begin
            if (bus.mm_finished) begin
               idx_s   = {INDEX_BITS{1'b0}};
               state_s = S_DADDR;
            end else if (TMO_EN && (tmo_r == TMO_LAST)) begin
               error_s = 1'b1;
               state_s = S_IDLE;
            end else begin
               tmo_s = tmo_r + TMO_W'(1);
            end
         end
         S_DADDR: begin
            state_s = S_DWRITE;
         end
         S_DWRITE: begin
            // Stall keeps idx, so the array's registered read data stays put.
            if (bus.wr_ready) begin
               if (idx_r == IDX_LAST) begin
                  state_s = S_DONE;
               end else begin
                  idx_s   = idx_r + INDEX_BITS'(1);
                  state_s = S_DADDR;
               end
            end else begin
               state_s = S_DWRITE;
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs, decoded from the next state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= S_IDLE;
         base_r     <= {INDEX_BITS{1'b0}};
         idx_r      <= {INDEX_BITS{1'b0}};
         clr_r      <= {CLR_W{1'b0}};
         tmo_r      <= {TMO_W{1'b0}};
         error_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         mm_reset_r <= 1'b1;
         wr_en_r    <= 1'b0;
         wr_addr_r  <= {INDEX_BITS{1'b0}};
         res_addr_r <= {INDEX_BITS{1'b0}};
      end else if (srst_s) begin
         state_r    <= S_IDLE;
         base_r     <= {INDEX_BITS{1'b0}};
         idx_r      <= {INDEX_BITS{1'b0}};
         clr_r      <= {CLR_W{1'b0}};
         tmo_r      <= {TMO_W{1'b0}};
         error_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         mm_reset_r <= 1'b1;
         wr_en_r    <= 1'b0;
         wr_addr_r  <= {INDEX_BITS{1'b0}};
         res_addr_r <= {INDEX_BITS{1'b0}};
      end else begin
         state_r    <= state_s;
         base_r     <= base_s;
         idx_r      <= idx_s;
         clr_r      <= clr_s;
         tmo_r      <= tmo_s;
         error_r    <= error_s;
         busy_r     <= (state_s != S_IDLE);
         done_r     <= (state_s == S_DONE);
         mm_reset_r <= !((state_s == S_RUN) || (state_s == S_DADDR) || (state_s == S_DWRITE));
         wr_en_r    <= (state_s == S_DWRITE);
         wr_addr_r  <= base_s + idx_s;
         res_addr_r <= idx_s;
      end
   end

   assign res_s           = bus.mm_res_out;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.error       = error_r;
   assign bus.mm_reset    = mm_reset_r;
   assign bus.mm_res_addr = res_addr_r;
   assign bus.wr_en       = wr_en_r;
   assign bus.wr_addr     = wr_addr_r;
   assign bus.wr_data     = res_s;
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed bench for mm_seq_ctrl with a small array model and a write
// monitor; expected addresses, sums and latencies are computed here.
module tb_mm_seq_ctrl;
   localparam int IB = 16;
   localparam int BR = 32;

   logic          clk;
   logic          reset;
   logic          fin_en;
   logic [BR-1:0] res_q;
   int            run_cnt  = 0;
   int            done_cnt = 0;
   int            n_chk    = 0;
   int            n_err    = 0;
   logic [IB-1:0] wa_q[$];
   logic [BR-1:0] wd_q[$];

   mm_seq_ctrl_if #(.INDEX_BITS(IB), .BIT_RES(BR)) bus ();

   mm_seq_ctrl #(
      .ROWS_OUT(3), .COLS_OUT(3), .INDEX_BITS(IB), .BIT_RES(BR),
      .CLEAR_CYCLES(2), .TIMEOUT(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   function automatic logic [BR-1:0] sum_of(input logic [IB-1:0] a);
      return 32'hC0DE_0000 + {16'h0000, a};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Array model (finished 12 cycles into RUN, registered read port) and write/done monitor.
   always @(posedge clk) begin
      if (bus.mm_reset) run_cnt <= 0;
      else              run_cnt <= run_cnt + 1;
      res_q <= sum_of(bus.mm_res_addr);
      if (bus.wr_en && bus.wr_ready) begin
         wa_q.push_back(bus.wr_addr);
         wd_q.push_back(bus.wr_data);
      end
      if (bus.done) done_cnt <= done_cnt + 1;
   end

   assign bus.mm_finished = fin_en && !bus.mm_reset && (run_cnt >= 11);
   assign bus.mm_res_out  = res_q;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic do_run(input logic [IB-1:0] base, input bit do_stall, input bit spur,
                         input int exp_lat);
      int            n, w0, d0, stall_seen;
      bit            busy_ok, held_ok;
      logic [IB-1:0] stall_a, ea;
      logic          err1;
      w0 = wa_q.size();
      d0 = done_cnt;
      stall_a = base + 16'd4;
      stall_seen = 0;
      busy_ok = 1'b1;
      held_ok = 1'b1;
      @(negedge clk);
      bus.start = 1'b1;
      bus.base_addr = base;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      err1 = bus.error;
      while (!bus.done && n < 200) begin
         if (!bus.busy) busy_ok = 1'b0;
         if (do_stall && bus.wr_en && bus.wr_addr == stall_a) begin
            stall_seen++;
            if (bus.wr_data !== sum_of(16'd4)) held_ok = 1'b0;
         end
         bus.wr_ready = !(do_stall && bus.wr_en && bus.wr_addr == stall_a && stall_seen <= 3);
         bus.start = spur && (n == 5);
         @(negedge clk);
         n++;
      end
      if (!bus.busy) busy_ok = 1'b0;
      bus.start = spur;
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_ready = 1'b1;
      chk("latency", n, exp_lat);
      chk("err_cleared", err1, 1'b0);
      chk("busy_during", busy_ok, 1'b1);
      chk("busy_after", bus.busy, 1'b0);
      chk("done_after", bus.done, 1'b0);
      chk("err_after", bus.error, 1'b0);
      chk("n_writes", wa_q.size() - w0, 9);
      for (int i = 0; i < 9; i++) begin
         if (w0 + i < wa_q.size()) begin
            ea = base + 16'(i);
            chk($sformatf("wr_addr[%0d]", i), wa_q[w0 + i], ea);
            chk($sformatf("wr_data[%0d]", i), wd_q[w0 + i], sum_of(16'(i)));
         end
      end
      if (do_stall) begin
         chk("stall_cycles", stall_seen, 4);
         chk("stall_hold", held_ok, 1'b1);
      end
      repeat (3) @(negedge clk);
      chk("n_done", done_cnt - d0, 1);
   endtask

   initial begin
      int n, last_busy, w0, d0, k;
      bit err_early;
      reset = 1'b0;
      fin_en = 1'b1;
      bus.start = 1'b0;
      bus.base_addr = 16'h0000;
      bus.wr_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_error", bus.error, 1'b0);
      chk("rst_wr_en", bus.wr_en, 1'b0);
      chk("rst_mm_reset", bus.mm_reset, 1'b1);
      chk("rst_res_addr", bus.mm_res_addr, 16'h0000);

      // Start held across the two synchroniser edges after release must be ignored.
      reset = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      chk("rel_edge1_busy", bus.busy, 1'b0);
      @(negedge clk);
      chk("rel_edge2_busy", bus.busy, 1'b0);
      bus.start = 1'b0;

      do_run(16'h0100, 1'b0, 1'b0, 33);
      do_run(16'h0100, 1'b1, 1'b0, 36);

      // Timeout: finished never rises.
      fin_en = 1'b0;
      w0 = wa_q.size();
      d0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      bus.base_addr = 16'h0100;
      @(negedge clk);
      bus.start = 1'b0;
      n = 1;
      last_busy = 0;
      err_early = 1'b0;
      while (bus.busy && n < 200) begin
         last_busy = n;
         if (bus.error) err_early = 1'b1;
         @(negedge clk);
         n++;
      end
      chk("tmo_last_busy", last_busy, 18);
      chk("tmo_err_early", err_early, 1'b0);
      chk("tmo_error", bus.error, 1'b1);
      chk("tmo_done", bus.done, 1'b0);
      @(negedge clk);
      chk("tmo_error_sticky", bus.error, 1'b1);
      chk("tmo_n_done", done_cnt - d0, 0);
      chk("tmo_n_writes", wa_q.size() - w0, 0);
      fin_en = 1'b1;

      do_run(16'h0100, 1'b0, 1'b1, 33);
      do_run(16'hFFFE, 1'b0, 1'b0, 33);

      // Abort with reset during DWRITE of idx 5.
      w0 = wa_q.size();
      d0 = done_cnt;
      @(negedge clk);
      bus.start = 1'b1;
      bus.base_addr = 16'h0200;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (!(bus.wr_en && bus.wr_addr == 16'h0205) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("abort_reached", k < 200, 1'b1);
      reset = 1'b0;
      #1;
      chk("abort_wr_en", bus.wr_en, 1'b0);
      chk("abort_mm_reset", bus.mm_reset, 1'b1);
      chk("abort_busy", bus.busy, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_n_writes", wa_q.size() - w0, 5);
      chk("abort_n_done", done_cnt - d0, 0);
      do_run(16'h0300, 1'b0, 1'b0, 33);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
